// File: rtl/screen_spi_if.sv
// Byte request handshake between the screen register logic and the SPI controller.
interface screen_spi_if;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       busy;

  modport master (
    output tx_data, tx_dc, tx_valid,
    input  tx_ready, tx_done, busy
  );

  modport slave (
    input  tx_data, tx_dc, tx_valid,
    output tx_ready, tx_done, busy
  );
endinterface

// File: rtl/screen_spi_ctrl.sv
// Mode-0 SPI byte sequencer for the static-screen display with gated per-byte SCK.
// Define SCREEN_SPI_BURST_EN to allow back-to-back bytes without a cs_n gap.
module screen_spi_ctrl #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk_fpga,
  input  logic         rst,
  screen_spi_if.slave  tx,
  output logic         sck,
  output logic         mosi,
  output logic         cs_n,
  output logic         dc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
`ifdef SCREEN_SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       half;
  logic [6:0]       shreg;
  logic             tx_ready_q;
  logic             tx_done_q;
  logic             busy_q;

  logic [CNT_W-1:0] cnt_next;
  logic             cnt_last;
  logic             hold_next_last;
  logic             accept;

  assign cnt_next       = cnt + CNT_W'(1);
  assign cnt_last       = (cnt == LAST);
  assign hold_next_last = (cnt_next == LAST);
  assign accept         = tx.tx_valid && tx_ready_q;

  assign tx.tx_ready = tx_ready_q;
  assign tx.tx_done  = tx_done_q;
  assign tx.busy     = busy_q;

  // Sequencer; tx_ready is only high in IDLE or (burst) the last HOLD cycle,
  // so an accept always restarts a byte with cs_n low.
  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      half       <= '0;
      shreg      <= '0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      dc         <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (accept) begin
        state      <= SETUP;
        cnt        <= '0;
        shreg      <= tx.tx_data[6:0];
        mosi       <= tx.tx_data[7];
        dc         <= tx.tx_dc;
        sck        <= 1'b0;
        cs_n       <= 1'b0;
        tx_ready_q <= 1'b0;
        busy_q     <= 1'b1;
      end else begin
        case (state)
          SETUP: begin
            if (cnt_last) begin
              state <= SHIFT;
              cnt   <= '0;
              half  <= '0;
              sck   <= 1'b1;
            end else begin
              cnt <= cnt_next;
            end
          end
          SHIFT: begin
            if (cnt_last) begin
              cnt <= '0;
              if (half == 4'd15) begin
                state      <= HOLD;
                tx_done_q  <= (LAST == '0);
                tx_ready_q <= BURST && (LAST == '0);
              end else begin
                half <= half + 4'd1;
                sck  <= half[0];
                // Entering low half-period i: present bit 6-i; bit0 then holds.
                if (!half[0] && half != 4'd14) begin
                  mosi  <= shreg[6];
                  shreg <= {shreg[5:0], 1'b0};
                end
              end
            end else begin
              cnt <= cnt_next;
            end
          end
          HOLD: begin
            if (cnt_last) begin
              state      <= GAP;
              cnt        <= '0;
              cs_n       <= 1'b1;
              tx_ready_q <= 1'b0;
            end else begin
              cnt        <= cnt_next;
              tx_done_q  <= hold_next_last;
              tx_ready_q <= BURST && hold_next_last;
            end
          end
          GAP: begin
            if (cnt_last) begin
              state      <= IDLE;
              cnt        <= '0;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              cnt <= cnt_next;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_screen_spi_ctrl.sv
// Bench for screen_spi_ctrl: three dividers (4, 1, 2) driven together and checked
// cycle by cycle against a timeline model, plus table vectors and corner sequences.
module tb_screen_spi_ctrl;

`ifdef SCREEN_SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_dc = 1'b0;
  logic [2:0] valid = 3'b000;

  screen_spi_if if4 ();
  screen_spi_if if1 ();
  screen_spi_if if2 ();

  logic sck_0, mosi_0, csn_0, dc_0;
  logic sck_1, mosi_1, csn_1, dc_1;
  logic sck_2, mosi_2, csn_2, dc_2;

  assign if4.tx_data = tx_data;  assign if4.tx_dc = tx_dc;  assign if4.tx_valid = valid[0];
  assign if1.tx_data = tx_data;  assign if1.tx_dc = tx_dc;  assign if1.tx_valid = valid[1];
  assign if2.tx_data = tx_data;  assign if2.tx_dc = tx_dc;  assign if2.tx_valid = valid[2];

  screen_spi_ctrl #(.DIV(4), .CNT_W(8)) u_div4 (
    .clk_fpga(clk), .rst(rst), .tx(if4), .sck(sck_0), .mosi(mosi_0), .cs_n(csn_0), .dc(dc_0));
  screen_spi_ctrl #(.DIV(1), .CNT_W(8)) u_div1 (
    .clk_fpga(clk), .rst(rst), .tx(if1), .sck(sck_1), .mosi(mosi_1), .cs_n(csn_1), .dc(dc_1));
  screen_spi_ctrl #(.DIV(2), .CNT_W(8)) u_div2 (
    .clk_fpga(clk), .rst(rst), .tx(if2), .sck(sck_2), .mosi(mosi_2), .cs_n(csn_2), .dc(dc_2));

  logic [2:0] o_sck, o_mosi, o_csn, o_dc, o_rdy, o_done, o_busy;
  assign o_sck  = {sck_2, sck_1, sck_0};
  assign o_mosi = {mosi_2, mosi_1, mosi_0};
  assign o_csn  = {csn_2, csn_1, csn_0};
  assign o_dc   = {dc_2, dc_1, dc_0};
  assign o_rdy  = {if2.tx_ready, if1.tx_ready, if4.tx_ready};
  assign o_done = {if2.tx_done, if1.tx_done, if4.tx_done};
  assign o_busy = {if2.busy, if1.busy, if4.busy};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // Timeline model state: last accepted byte and the cycle it was accepted in.
  bit         have[3];
  int         t0[3];
  logic [7:0] mb[3];
  logic       mdc[3];
  int         acc_cnt[3];

  // Rise-sampled capture, snapshotted at each tx_done.
  logic [7:0] cap_bits[3];
  int         rises[3];
  int         seen_acc[3];
  logic [2:0] sck_prev = 3'b000;
  logic [7:0] snap_byte[3];
  logic       snap_dc[3];
  int         snap_rises[3];
  int         snap_lat[3];
  int         done_cnt[3];

  typedef struct packed {
    logic sck, mosi, cs_n, dc, rdy, done, busy;
  } exp_t;

  function automatic int div_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic bit model_ready(input int i);
    int k, d;
    k = cyc - t0[i];
    d = div_of(i);
    return !have[i] || (k > 19 * d) || (BURST && k == 18 * d);
  endfunction

  // Expected outputs k cycles after the accepting edge of byte b.
  function automatic exp_t exp_out(input bit hv, input int k, input int d,
                                   input logic [7:0] b, input logic dcv);
    exp_t e;
    int n;
    e = '0;
    e.dc = dcv;
    if (!hv) begin
      e.cs_n = 1'b1;
      e.rdy  = 1'b1;
    end else begin
      e.busy = (k <= 19 * d);
      e.rdy  = (k > 19 * d) || (BURST && k == 18 * d);
      e.cs_n = !(k >= 1 && k <= 18 * d);
      e.sck  = (k >= d + 1) && (k <= 17 * d) && ((((k - d - 1) / d) % 2) == 0);
      e.done = (k == 18 * d);
      if (k <= d) begin
        e.mosi = b[7];
      end else begin
        n = (((k - d - 1) / d) + 1) / 2;
        if (n > 7) n = 7;
        e.mosi = b[7 - n];
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int i, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%b exp=%b", nm, i, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int i, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", nm, i, cyc, got, exp);
    end
  endtask

  // Model update on the active edge, from the inputs the DUTs sample.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        have[i] = 1'b0;
        mdc[i]  = 1'b0;
      end else if (valid[i] && model_ready(i)) begin
        have[i] = 1'b1;
        t0[i]   = cyc;
        mb[i]   = tx_data;
        mdc[i]  = tx_dc;
        acc_cnt[i]++;
      end
    end
    if (rst) armed = 1'b1;
    cyc++;
  end

  // Per-cycle comparison and rise-edge capture on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        e = exp_out(have[i], cyc - t0[i], div_of(i), mb[i], mdc[i]);
        chk("sck", i, o_sck[i], e.sck);
        chk("mosi", i, o_mosi[i], e.mosi);
        chk("cs_n", i, o_csn[i], e.cs_n);
        chk("dc", i, o_dc[i], e.dc);
        chk("tx_ready", i, o_rdy[i], e.rdy);
        chk("tx_done", i, o_done[i], e.done);
        chk("busy", i, o_busy[i], e.busy);
        if (rst) begin
          cap_bits[i] = 8'h00;
          rises[i]    = 0;
        end else begin
          if (acc_cnt[i] != seen_acc[i]) begin
            seen_acc[i] = acc_cnt[i];
            cap_bits[i] = 8'h00;
            rises[i]    = 0;
          end
          if (o_sck[i] && !sck_prev[i]) begin
            cap_bits[i] = {cap_bits[i][6:0], o_mosi[i]};
            rises[i]++;
          end
          if (o_done[i]) begin
            snap_byte[i]  = cap_bits[i];
            snap_dc[i]    = o_dc[i];
            snap_rises[i] = rises[i];
            snap_lat[i]   = cyc - t0[i];
            done_cnt[i]++;
          end
        end
        sck_prev[i] = o_sck[i];
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic dv);
    int snap[3];
    tx_data = d;
    tx_dc   = dv;
    for (int i = 0; i < 3; i++) snap[i] = acc_cnt[i];
    valid = 3'b111;
    for (int n = 0; n < 200 && valid != 3'b000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (acc_cnt[i] != snap[i]) valid[i] = 1'b0;
    end
    checks++;
    if (valid != 3'b000) begin
      errors++;
      $display("FAIL accept_timeout pending=%b", valid);
      valid = 3'b000;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 400 && o_busy != 3'b000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_busy != 3'b000) begin
      errors++;
      $display("FAIL idle_timeout busy=%b", o_busy);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_byte;
    int         exp_rises;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   d0[3];
    int   base, gap, first_done, second_done;

    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 8};
    tbl[1] = '{8'h3C, 1'b0, 8'h3C, 8};
    tbl[2] = '{8'h81, 1'b1, 8'h81, 8};
    tbl[3] = '{8'h00, 1'b0, 8'h00, 8};
    tbl[4] = '{8'h7E, 1'b1, 8'h7E, 8};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors on all three dividers.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
      send(tbl[r].data, tbl[r].dc);
      wait_idle();
      for (int i = 0; i < 3; i++) begin
        chk_int("done_count", i, done_cnt[i], d0[i] + 1);
        chk_int("byte", i, int'(snap_byte[i]), int'(tbl[r].exp_byte));
        chk("dc_latched", i, snap_dc[i], tbl[r].dc);
        chk_int("rises", i, snap_rises[i], tbl[r].exp_rises);
        chk_int("done_lat", i, snap_lat[i], 18 * div_of(i));
      end
    end

    // Requests while busy are ignored and data changes have no effect.
    for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
    send(8'hFF, 1'b1);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      tx_data = 8'h00;
      tx_dc   = 1'b0;
      for (int i = 0; i < 3; i++)
        valid[i] = (n % 2 == 0) && have[i] && ((cyc - t0[i]) < 17 * div_of(i));
    end
    valid = 3'b000;
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      chk_int("ignored_done_count", i, done_cnt[i], d0[i] + 1);
      chk_int("ignored_byte", i, int'(snap_byte[i]), 8'hFF);
      chk_int("ignored_rises", i, snap_rises[i], 8);
    end

    // Reset in the middle of the DIV=4 shift phase aborts without tx_done.
    send(8'hA5, 1'b1);
    repeat (30) @(negedge clk);
    d0[0] = done_cnt[0];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sck", 0, o_sck[0], 1'b0);
    chk("rst_cs_n", 0, o_csn[0], 1'b1);
    chk("rst_ready", 0, o_rdy[0], 1'b1);
    chk("rst_busy", 0, o_busy[0], 1'b0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk_int("rst_no_done", 0, done_cnt[0], d0[0]);

    // Back-to-back with tx_valid held high (DIV=2 instance measured).
    tx_data = 8'h01;
    tx_dc   = 1'b0;
    base = acc_cnt[2];
    d0[2] = done_cnt[2];
    gap = 0;
    first_done = -1;
    second_done = -1;
    valid = 3'b111;
    for (int n = 0; n < 300 && second_done < 0; n++) begin
      @(negedge clk);
      #1;
      if (acc_cnt[2] == base + 1) begin
        tx_data = 8'h80;
        tx_dc   = 1'b1;
      end
      if (acc_cnt[2] >= base + 2) valid = 3'b000;
      if (done_cnt[2] == d0[2] + 1) begin
        if (first_done < 0) first_done = cyc;
        if (o_csn[2] && o_busy[2]) gap++;
      end
      if (done_cnt[2] == d0[2] + 2) second_done = cyc;
    end
    valid = 3'b000;
    chk_int("b2b_seen", 2, int'(second_done >= 0), 1);
    chk_int("b2b_gap", 2, gap, BURST ? 0 : 2);
    chk_int("b2b_period", 2, second_done - first_done, BURST ? 36 : 39);
    chk_int("b2b_byte2", 2, int'(snap_byte[2]), 8'h80);
    chk("b2b_dc2", 2, snap_dc[2], 1'b1);
    wait_idle();

    // Random traffic against the timeline model.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      tx_data = 8'($urandom);
      tx_dc   = 1'($urandom);
      for (int i = 0; i < 3; i++) valid[i] = ($urandom_range(3) == 0);
    end
    valid = 3'b000;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/screen_spi_ctrl.md
Name: screen_spi_ctrl

Overview:
- SPI byte transmitter and sequencer for the static-screen display link.
- Accepts one byte plus a data/command flag per valid/ready handshake.
- Generates SCK from clk_fpga with an internal programmable divider, and drives cs_n, dc and mosi in SPI mode 0 (SCK idle low, MOSI changes on falling edge, display samples on rising edge).
- Sits between the Wishbone screen register logic and the display pins, and replaces free-running SCK generation with gated, per-byte SCK.

Parameters:
- DIV, 4: half-period of SCK in clk_fpga cycles; legal range 1..255. Also sets the lengths of SETUP, HOLD and GAP.
- CNT_W, 8: width of the internal half-period counter; must hold DIV-1.

Ports:
- clk_fpga  in   1  system clock; all logic on rising edge
- rst       in   1  synchronous, active-high reset
- tx_data   in   8  byte to send, MSB first
- tx_dc     in   1  data/command flag, latched with tx_data (1 = data, 0 = command)
- tx_valid  in   1  request; a transfer is accepted when tx_valid && tx_ready on a rising edge
- tx_ready  out  1  controller can accept a byte
- tx_done   out  1  one-cycle pulse when a byte's SCK activity is complete
- busy      out  1  high in every state except IDLE
- sck       out  1  SPI clock to display
- mosi      out  1  serial data to display
- cs_n      out  1  display chip select, active low
- dc        out  1  latched data/command line to display

Behaviour:
- Reset (synchronous, rst=1 sampled on clk_fpga edge):
  - State goes to IDLE. Outputs: sck=0, mosi=0, cs_n=1, dc=0, tx_ready=1, tx_done=0, busy=0.
  - Reset mid-transfer aborts on the same edge: no tx_done pulse, shift register and counter cleared.
- IDLE:
  - cs_n=1, sck=0, tx_ready=1.
  - On accept, latch tx_data into the shift register and tx_dc into dc, clear the counter, and go to SETUP.
  - tx_ready drops on the next cycle.
- SETUP (DIV cycles):
  - cs_n=0, sck=0, mosi=bit7.
  - After DIV cycles, go to SHIFT.
- SHIFT (16 half-periods of DIV cycles each):
  - Half-periods alternate, starting with sck=1.
  - On entry to each low half-period i (i=0..6), mosi advances to bit 6-i.
  - After the 16th half-period (sck low), go to HOLD.
  - Exactly 8 rising edges per byte.
- HOLD (DIV cycles):
  - cs_n=0, sck=0, mosi holds bit0.
  - tx_done=1 on the last HOLD cycle; then go to GAP.
- GAP (DIV cycles):
  - cs_n=1, sck=0; then go to IDLE.
- Timing: accept at cycle t0 gives cs_n falling at t0+1, first sck rise at t0+DIV+1, tx_done at t0+18*DIV, and tx_ready=1 at t0+19*DIV+1.
- Counter compares against DIV-1. DIV=1 gives a toggle every cycle with no skipped or extra edges.
- tx_valid while tx_ready=0 is ignored. tx_data and tx_dc changes mid-transfer have no effect.
- dc is stable from cs_n fall until cs_n rise.

Optional Feature:
- SCREEN_SPI_BURST_EN defined:
  - tx_ready is also 1 on the last HOLD cycle (same cycle as tx_done).
  - An accept there latches the new byte and goes directly to SETUP with cs_n held low (GAP skipped).
  - Back-to-back byte period is 18*DIV cycles.
  - If there is no accept on that cycle, proceed to GAP as normal.
- Not defined: tx_ready only in IDLE. cs_n deasserts for DIV cycles between every byte.

Test Plan:
- Reset: hold rst=1 for 3 cycles mid-SHIFT, DIV=4 -> next edge shows sck=0, cs_n=1, tx_ready=1, busy=0, no tx_done pulse.
- Single byte: DIV=4, send 0xA5 with dc=1 -> cs_n low at t0+1, 8 sck rises sampled as 1,0,1,0,0,1,0,1, dc=1 throughout, tx_done at t0+72, tx_ready at t0+77.
- Minimum divider: DIV=1, send 0x3C with dc=0 -> sck period 2 cycles, rise-sampled bits 00111100, tx_done at t0+18, dc=0.
- Ignored request: during a 0xFF transfer, toggle tx_valid with 0x00 -> 0x00 never transmitted, exactly 8 rises, data all 1s.
- Back-to-back, no burst: keep tx_valid high with 0x01 then 0x80, DIV=2 -> cs_n high for exactly 2 cycles between bytes, second accept at IDLE.
- Burst (SCREEN_SPI_BURST_EN, DIV=2): stream 0x12, 0x34 with dc 0 then 1 -> cs_n stays low across both, second accept on the tx_done cycle, dc switches to 1 in the cycle after the accept (during SETUP, before the first rise of byte 2), period 36 cycles.
